pattern_tx: RTL and testbench



---
 rtl/pattern_tx.sv | 144 ++++++++++++++
 tb/tb_pattern_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a latched W-bit pattern out MSB-first, repeating it
// a programmable number of times with an optional one-cycle idle gap between repeats.
// Reports progress through busy and a one-cycle done pulse after the final bit.
module pattern_tx #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             gap_en,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = $clog2(W);
  localparam logic [BitW-1:0] BitsMax = BitW'(W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     save_q, save_d;
  logic [BitW-1:0]  bits_q, bits_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic             gap_q, gap_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and registered-output decode; every output defaults to its idle value.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    save_d  = save_q;
    bits_d  = bits_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (repeat_n == '0) begin
            // Empty burst: acknowledge immediately, send nothing.
            done_d = 1'b1;
          end else begin
            // First bit leaves on the same edge that accepts the request.
            out_d   = pattern[W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
            shreg_d = pattern << 1;
            save_d  = pattern;
            bits_d  = BitsMax;
            reps_d  = repeat_n;
            gap_d   = gap_en;
            state_d = StSend;
          end
        end
      end

      StSend: begin
        busy_d = 1'b1;
        if (bits_q != '0) begin
          out_d   = shreg_q[W-1];
          valid_d = 1'b1;
          shreg_d = shreg_q << 1;
          bits_d  = bits_q - 1'b1;
        end else if (reps_q > CNT_W'(1)) begin
          reps_d = reps_q - CNT_W'(1);
          if (gap_q) begin
            state_d = StGap;
          end else begin
            // Reload on this edge so repeats run back-to-back.
            out_d   = save_q[W-1];
            valid_d = 1'b1;
            shreg_d = save_q << 1;
            bits_d  = BitsMax;
          end
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      StGap: begin
        out_d   = save_q[W-1];
        valid_d = 1'b1;
        busy_d  = 1'b1;
        shreg_d = save_q << 1;
        bits_d  = BitsMax;
        state_d = StSend;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      save_q  <= '0;
      bits_q  <= '0;
      reps_q  <= '0;
      gap_q   <= 1'b0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      save_q  <= save_d;
      bits_q  <= bits_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: hand-computed bit streams compared cycle by cycle.
module tb_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeat_n;
  logic       gap_en;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  pattern_tx #(
    .W    (4),
    .CNT_W(4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .gap_en   (gap_en),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " out"}, 32'(out), 32'd0);
    check_eq({tag, " valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // Pulse start for one edge; returns in the first cycle of the burst.
  task automatic start_burst(input logic [3:0] p, input logic [3:0] r, input logic g);
    pattern  = p;
    repeat_n = r;
    gap_en   = g;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Check n cycles of the burst (vectors MSB = first cycle), then the done cycle.
  // At cycle 'poke' a start pulse and new pattern/repeat_n are applied; they must be ignored.
  task automatic expect_burst(input string tag, input int n, input logic [31:0] eo,
                              input logic [31:0] ev, input int poke);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s out[%0d]", tag, i), 32'(out), 32'(eo[n-1-i]));
      check_eq($sformatf("%s valid[%0d]", tag, i), 32'(out_valid), 32'(ev[n-1-i]));
      check_eq($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
      check_eq($sformatf("%s done[%0d]", tag, i), 32'(done), 32'd0);
      if (i == poke) begin
        start    = 1'b1;
        pattern  = 4'b0010;
        repeat_n = 4'd1;
      end else if (i == poke + 1) begin
        start = 1'b0;
      end
      step();
    end
    check_eq({tag, " done pulse"}, 32'(done), 32'd1);
    check_idle({tag, " done cycle"});
    step();
    check_eq({tag, " done clear"}, 32'(done), 32'd0);
    check_idle({tag, " after"});
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    repeat_n = '0;
    gap_en   = 1'b0;

    // Reset state
    #2;
    check_idle("reset");
    check_eq("reset done", 32'(done), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    check_idle("post reset");

    // Single burst
    start_burst(4'b1101, 4'd1, 1'b0);
    expect_burst("single", 4, 32'b1101, 32'b1111, -1);

    // Repeats with gap
    start_burst(4'b1101, 4'd2, 1'b1);
    expect_burst("gap", 9, 32'b110101101, 32'b111101111, -1);

    // Repeats without gap
    start_burst(4'b1101, 4'd2, 1'b0);
    expect_burst("nogap", 8, 32'b11011101, 32'b11111111, -1);

    // Zero repeats
    start_burst(4'b1101, 4'd0, 1'b0);
    check_eq("zero done", 32'(done), 32'd1);
    check_idle("zero");
    step();
    check_eq("zero done clear", 32'(done), 32'd0);
    check_idle("zero after");

    // Inputs ignored while busy
    start_burst(4'b1101, 4'd3, 1'b0);
    expect_burst("ignore", 12, 32'b110111011101, 32'hFFF, 2);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("ignore no extra done", 32'(done), 32'd0);
      check_idle("ignore quiet");
    end

    // Maximum repeat count: 15 x 4 valid bits, no counter wrap
    start_burst(4'b1001, 4'd15, 1'b0);
    cnt = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (out_valid) cnt++;
      step();
    end
    check_eq("max reps valid count", 32'(cnt), 32'd60);
    check_eq("max reps done", 32'(done), 32'd1);
    step();

    // Back-to-back with start held high
    pattern  = 4'b1011;
    repeat_n = 4'd1;
    gap_en   = 1'b0;
    start    = 1'b1;
    step();
    begin
      logic [9:0] eo, ev, ed;
      eo = 10'b1011010110;
      ev = 10'b1111011110;
      ed = 10'b0000100001;
      for (int i = 0; i < 10; i++) begin
        check_eq($sformatf("b2b out[%0d]", i), 32'(out), 32'(eo[9-i]));
        check_eq($sformatf("b2b valid[%0d]", i), 32'(out_valid), 32'(ev[9-i]));
        check_eq($sformatf("b2b busy[%0d]", i), 32'(busy), 32'(ev[9-i]));
        check_eq($sformatf("b2b done[%0d]", i), 32'(done), 32'(ed[9-i]));
        if (i == 9) start = 1'b0;
        step();
      end
    end
    check_idle("b2b stop");

    // Asynchronous reset mid-burst while out=1
    start_burst(4'b1101, 4'd3, 1'b0);
    check_eq("arst pre out", 32'(out), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_idle("arst async");
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("arst released");
      check_eq("arst released done", 32'(done), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
